// File: rtl/uart_rx_ctrl.sv
// UART receive control: prescale/parity configuration, FWFT receive FIFO, sticky status.
// Optional per-cycle error counters are built when UART_RX_ERR_CNT_EN is defined.
module uart_rx_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 8,
    parameter int PRSC_WIDTH = 6
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_cfg_we,
    input  logic [PRSC_WIDTH+1:0]   i_cfg_wdata,
    output logic [PRSC_WIDTH-1:0]   o_prescale,
    output logic                    o_parity_enable,
    output logic                    o_parity_type,
    output logic                    o_cfg_err,
    input  logic                    i_rx_data_valid,
    input  logic [WIDTH-1:0]        i_rx_data,
    input  logic                    i_rx_parity_error,
    input  logic                    i_rx_stop_error,
    output logic                    o_rd_valid,
    output logic [WIDTH-1:0]        o_rd_data,
    input  logic                    i_rd_en,
    output logic                    o_full,
    output logic                    o_overrun,
    output logic                    o_par_err,
    output logic                    o_stop_err,
    input  logic                    i_clr_status,
    output logic [7:0]              o_par_err_cnt,
    output logic [7:0]              o_stop_err_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PRSC_WIDTH-1:0] PRSC_8  = PRSC_WIDTH'(8);
    localparam logic [PRSC_WIDTH-1:0] PRSC_16 = PRSC_WIDTH'(16);
    localparam logic [PRSC_WIDTH-1:0] PRSC_32 = PRSC_WIDTH'(32);

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          count;

    logic [PRSC_WIDTH-1:0]  cfg_prescale;
    logic                   cfg_legal;
    logic                   push_req;
    logic                   push;
    logic                   pop;
    logic                   overrun_set;

    // 32 is only representable once the prescale field is at least 6 bits wide
    always_comb begin
        cfg_prescale = i_cfg_wdata[PRSC_WIDTH-1:0];
        cfg_legal    = (cfg_prescale == PRSC_8) || (cfg_prescale == PRSC_16) ||
                       ((PRSC_WIDTH >= 6) && (cfg_prescale == PRSC_32));
    end

    assign o_rd_valid = (count != '0);
    assign o_full     = (count == FULL_CNT);
    assign o_rd_data  = o_rd_valid ? mem[rd_ptr] : '0;

    // Errored frames never enter the FIFO; a full FIFO still accepts a push when popped
    assign push_req    = i_rx_data_valid & ~i_rx_parity_error & ~i_rx_stop_error;
    assign pop         = i_rd_en & o_rd_valid;
    assign push        = push_req & (~o_full | pop);
    assign overrun_set = push_req & o_full & ~pop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_prescale      <= PRSC_16;
            o_parity_enable <= 1'b0;
            o_parity_type   <= 1'b0;
            o_cfg_err       <= 1'b0;
        end else begin
            if (i_cfg_we && cfg_legal) begin
                o_prescale      <= cfg_prescale;
                o_parity_enable <= i_cfg_wdata[PRSC_WIDTH];
                o_parity_type   <= i_cfg_wdata[PRSC_WIDTH+1];
            end
            o_cfg_err <= (i_cfg_we & ~cfg_legal) | (o_cfg_err & ~i_clr_status);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_rx_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as a clear leaves the flag set
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overrun  <= 1'b0;
            o_par_err  <= 1'b0;
            o_stop_err <= 1'b0;
        end else begin
            o_overrun  <= overrun_set       | (o_overrun  & ~i_clr_status);
            o_par_err  <= i_rx_parity_error | (o_par_err  & ~i_clr_status);
            o_stop_err <= i_rx_stop_error   | (o_stop_err & ~i_clr_status);
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    // Clear and increment together leave the count at one
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_par_err_cnt  <= 8'd0;
            o_stop_err_cnt <= 8'd0;
        end else begin
            if (i_rx_parity_error) begin
                o_par_err_cnt <= i_clr_status ? 8'd1 : sat_inc(o_par_err_cnt);
            end else if (i_clr_status) begin
                o_par_err_cnt <= 8'd0;
            end
            if (i_rx_stop_error) begin
                o_stop_err_cnt <= i_clr_status ? 8'd1 : sat_inc(o_stop_err_cnt);
            end else if (i_clr_status) begin
                o_stop_err_cnt <= 8'd0;
            end
        end
    end
`else
    assign o_par_err_cnt  = 8'd0;
    assign o_stop_err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (WIDTH=8, DEPTH=8, PRSC_WIDTH=6).
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [7:0] cfg_wdata;
    logic [5:0] prescale;
    logic       parity_enable;
    logic       parity_type;
    logic       cfg_err;
    logic       rx_data_valid;
    logic [7:0] rx_data;
    logic       rx_parity_error;
    logic       rx_stop_error;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_en;
    logic       full;
    logic       overrun;
    logic       par_err;
    logic       stop_err;
    logic       clr_status;
    logic [7:0] par_err_cnt;
    logic [7:0] stop_err_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    uart_rx_ctrl #(.WIDTH(8), .DEPTH(8), .PRSC_WIDTH(6)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_cfg_we          (cfg_we),
        .i_cfg_wdata       (cfg_wdata),
        .o_prescale        (prescale),
        .o_parity_enable   (parity_enable),
        .o_parity_type     (parity_type),
        .o_cfg_err         (cfg_err),
        .i_rx_data_valid   (rx_data_valid),
        .i_rx_data         (rx_data),
        .i_rx_parity_error (rx_parity_error),
        .i_rx_stop_error   (rx_stop_error),
        .o_rd_valid        (rd_valid),
        .o_rd_data         (rd_data),
        .i_rd_en           (rd_en),
        .o_full            (full),
        .o_overrun         (overrun),
        .o_par_err         (par_err),
        .o_stop_err        (stop_err),
        .i_clr_status      (clr_status),
        .o_par_err_cnt     (par_err_cnt),
        .o_stop_err_cnt    (stop_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs set before the call are captured, outputs read 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        rx_data_valid = 1'b1;
        rx_data       = d;
        tick();
        rx_data_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_cnt;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_wdata = '0; rx_data_valid = 1'b0; rx_data = '0;
        rx_parity_error = 1'b0; rx_stop_error = 1'b0; rd_en = 1'b0; clr_status = 1'b0;
        tick(); tick();

        chk("rst_prescale", prescale, 32'd16);
        chk("rst_par_en", parity_enable, 0);
        chk("rst_par_type", parity_type, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_full", full, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_flags", {cfg_err, overrun, par_err, stop_err}, 0);
        chk("rst_cnts", {par_err_cnt, stop_err_cnt}, 0);
        rst_n = 1'b1;
        tick();

        // Legal config: 0x0A0 -> prescale 32, parity off, type 1
        cfg_we = 1'b1; cfg_wdata = 8'hA0;
        tick();
        cfg_we = 1'b0;
        chk("cfg32_prescale", prescale, 32'd32);
        chk("cfg32_par_type", parity_type, 1);
        chk("cfg32_par_en", parity_enable, 0);
        chk("cfg32_err", cfg_err, 0);

        cfg_we = 1'b1; cfg_wdata = 8'h48;
        tick();
        chk("cfg8_prescale", prescale, 32'd8);
        chk("cfg8_par_en", parity_enable, 1);
        cfg_wdata = 8'h10;
        tick();
        chk("cfg16_cfg", {parity_type, parity_enable, 2'b00, prescale}, 32'h10);

        // Illegal prescale 12 is rejected and flags the error until cleared
        cfg_wdata = 8'hCC;
        tick();
        cfg_we = 1'b0;
        chk("cfg12_cfg", {parity_type, parity_enable, 2'b00, prescale}, 32'h10);
        chk("cfg12_err", cfg_err, 1);
        tick(); tick();
        chk("cfg12_err_held", cfg_err, 1);
        pulse_clr();
        chk("cfg12_err_clr", cfg_err, 0);
        chk("clr_keeps_cfg", prescale, 32'd16);

        // Fill, overrun, drain in order
        push_byte(8'h11);
        chk("fwft_valid", rd_valid, 1);
        chk("fwft_data", rd_data, 32'h11);
        for (int i = 1; i < 8; i++) push_byte(8'h11 + 8'(i));
        chk("full_8", full, 1);
        chk("no_overrun_8", overrun, 0);
        push_byte(8'h99);
        chk("overrun_9", overrun, 1);
        chk("full_9", full, 1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("pop_%0d", i), rd_data, 32'h11 + i);
            chk($sformatf("pop_vld_%0d", i), rd_valid, 1);
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        chk("drained_valid", rd_valid, 0);
        chk("drained_data", rd_data, 0);
        pulse_clr();
        chk("overrun_clr", overrun, 0);

        // Pop on empty does nothing
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("pop_empty_valid", rd_valid, 0);
        chk("pop_empty_ovr", overrun, 0);
        push_byte(8'h3C);
        chk("after_empty_pop", rd_data, 32'h3C);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;

        // Simultaneous push/pop while full
        for (int i = 0; i < 8; i++) push_byte(8'h21 + 8'(i));
        chk("full_b", full, 1);
        rx_data_valid = 1'b1; rx_data = 8'h55; rd_en = 1'b1;
        tick();
        rx_data_valid = 1'b0; rd_en = 1'b0;
        chk("pp_full", full, 1);
        chk("pp_no_overrun", overrun, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("pp_pop_%0d", i), rd_data, (i == 7) ? 32'h55 : 32'h22 + i);
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        chk("pp_empty", rd_valid, 0);

        // Errored frame is never pushed
        rx_data_valid = 1'b1; rx_data = 8'h77; rx_parity_error = 1'b1;
        tick();
        rx_data_valid = 1'b0; rx_parity_error = 1'b0;
        chk("err_frame_nopush", rd_valid, 0);
        chk("err_frame_par", par_err, 1);
        pulse_clr();
        chk("par_clr", par_err, 0);
        chk("par_cnt_clr", par_err_cnt, 0);

        // Three parity pulses, then clear coincident with a stop error
        for (int i = 0; i < 3; i++) begin
            rx_parity_error = 1'b1;
            tick();
            rx_parity_error = 1'b0;
            tick();
        end
        chk("par3_flag", par_err, 1);
`ifdef UART_RX_ERR_CNT_EN
        exp_cnt = 8'd3;
`else
        exp_cnt = 8'd0;
`endif
        chk("par3_cnt", par_err_cnt, exp_cnt);
        clr_status = 1'b1; rx_stop_error = 1'b1;
        tick();
        clr_status = 1'b0; rx_stop_error = 1'b0;
        chk("clr_par", par_err, 0);
        chk("clr_stop_set_wins", stop_err, 1);
`ifdef UART_RX_ERR_CNT_EN
        exp_cnt = 8'd1;
`else
        exp_cnt = 8'd0;
`endif
        chk("clr_stop_cnt", stop_err_cnt, exp_cnt);
        chk("clr_par_cnt", par_err_cnt, 0);

        // Asynchronous reset mid-cycle with 4 entries held
        cfg_we = 1'b1; cfg_wdata = 8'h20;
        tick();
        cfg_we = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(8'hA0 + 8'(i));
        chk("hold4_valid", rd_valid, 1);
        chk("hold4_prescale", prescale, 32'd32);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", rd_valid, 0);
        chk("arst_prescale", prescale, 32'd16);
        chk("arst_data", rd_data, 0);
        chk("arst_flags", {full, overrun, par_err, stop_err}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_empty", rd_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
